exu_wb_arb: RTL and testbench
=============================

# exu_wb_arb

Writeback collector at the output end of the execute stage. It accepts completed results from the four single-cycle ALU pipes and the multiplier through valid/ready handshakes. Each source has a 2-entry buffer. A round-robin arbiter drains up to two results per cycle onto the two physical-register-file writeback ports. A pipeline flush clears all buffered, not-yet-written results.

## Interface
Parameters:
- DATA_W, 32, result width
- PREG_W, 6, physical destination register index width
- ROB_W, 6, reorder-buffer tag width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous pipeline flush
- src_valid  in  5  per-source result valid; index 0..3 = ALU pipes 1..4, index 4 = multiplier
- src_ready  out  5  per-source buffer can accept
- src_data  in  5*DATA_W  per-source result, source i at bits [i*DATA_W +: DATA_W]
- src_preg  in  5*PREG_W  per-source destination register, packed as above
- src_rob  in  5*ROB_W  per-source ROB tag, packed as above
- wb0_valid, wb1_valid  out  1  writeback port valid
- wb0_data, wb1_data  out  DATA_W  writeback data
- wb0_preg, wb1_preg  out  PREG_W  writeback destination register
- wb0_rob, wb1_rob  out  ROB_W  writeback ROB tag
- wb0_src, wb1_src  out  3  granted source index (debug/verification)

## Operation
- Per source: 2-entry FIFO holding {data, preg, rob}.
  - Each FIFO has a write pointer, a read pointer and a 2-bit count, range 0..2.
- Accept rule:
  - src_ready[i] = (count[i] != 2) && !flush.
  - A push happens when src_valid[i] && src_ready[i].
  - There is no bypass. A full FIFO does not accept, even when it pops in the same cycle.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers are 1 bit and wrap 1->0.
- Head valid: hv[i] = (count[i] != 0).
- Arbitration uses a round-robin pointer rr, range 0..4, reset 0.
  - Port 0 grant: the first i with hv[i], scanning rr, rr+1, ... mod 5.
  - Port 1 grant: the next hv source after the port-0 grant, in the same scan order.
  - A source never receives both ports in one cycle, even with 2 entries.
- Writeback ports have no backpressure. A granted head pops in the same cycle.
- rr update:
  - Two grants: rr = (port-1 source + 1) mod 5.
  - One grant: rr = (port-0 source + 1) mod 5.
  - No grant: rr unchanged.
- Port ordering:
  - wb1_valid is never asserted without wb0_valid.
  - wb*_data, wb*_preg, wb*_rob and wb*_src are don't-care when the matching valid is low; the implementation drives 0.
- flush:
  - Next edge: all counts and pointers go to 0 and rr goes to 0.
  - In the flush cycle: wb0_valid = wb1_valid = 0 and src_ready = 0, so no pop and no push occur.
  - Inputs presented during flush are dropped.
- Reset (rst_n low at an edge): same effect as flush. While rst_n is low, all outputs are 0, including src_ready.

## Timing
- Output behaviour:
  - wb* outputs are combinational from the FIFO heads and rr, with no registered output stage.
  - src_ready is combinational from count and flush only, never from src_valid.
- Latency: a result accepted at edge N is eligible for writeback in the cycle after edge N. Minimum latency is 1 cycle.
- Throughput:
  - 2 results per cycle sustained overall.
  - 1 per cycle per source, given the no-bypass rule and a continuously granted source.
- Reset outputs: src_ready = 0 during reset, 5'b11111 the first cycle after release. wb0_valid = wb1_valid = 0, and all wb data/preg/rob/src = 0.
- Reset or flush mid-operation discards buffered entries. No partial writeback of a discarded entry occurs.

## Test plan
- Reset then single push: src_valid = 5'b00001, data 0x1234, preg 5, rob 3 at edge 1 -> wb0_valid = 1, data 0x1234, preg 5, rob 3, src 0 in cycle 2; wb1_valid = 0; rr = 1 afterwards.
- Round-robin fairness: fill all five FIFOs with 2 entries each, then no more inputs.
  - Grants (port0, port1): (0,1), (2,3), (4,0), (1,2), (3,4).
  - All FIFOs empty after 5 cycles.
- Full no-bypass: hold src_valid[4] = 1 while the other sources are saturated.
  - src_ready[4] deasserts exactly when count = 2 and stays low in a pop cycle.
  - Accepted data order is preserved through the pointer wrap.
- Flush with pending data: 3 FIFOs non-empty, flush = 1 together with src_valid = 5'b11111.
  - Flush cycle: no wb valid, src_ready = 0.
  - Next cycle: all heads empty, no writebacks, rr = 0, inputs dropped.
- Reset mid-stream: assert rst_n = 0 for 1 cycle while 2 entries are buffered -> no later writeback of those entries; src_ready = 5'b11111 after release.
- Randomized scoreboard:
  - Random valids, 2000 cycles.
  - Every accepted (source, rob) is written back exactly once, in per-source FIFO order.
  - A source never holds both ports in one cycle; wb1_valid implies wb0_valid.

Source files
------------

// File: rtl/exu_wb_arb.sv
// exu_wb_arb: execute-stage writeback collector.
// Five result sources (ALU pipes 0..3, multiplier 4) each feed a 2-entry FIFO.
// A round-robin arbiter drains up to two FIFO heads per cycle onto the two
// register-file writeback ports. Flush and reset both discard everything buffered.
module exu_wb_arb #(
    parameter int DATA_W = 32,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [4:0]           src_valid,
    output logic [4:0]           src_ready,
    input  logic [5*DATA_W-1:0]  src_data,
    input  logic [5*PREG_W-1:0]  src_preg,
    input  logic [5*ROB_W-1:0]   src_rob,
    output logic                 wb0_valid,
    output logic [DATA_W-1:0]    wb0_data,
    output logic [PREG_W-1:0]    wb0_preg,
    output logic [ROB_W-1:0]     wb0_rob,
    output logic [2:0]           wb0_src,
    output logic                 wb1_valid,
    output logic [DATA_W-1:0]    wb1_data,
    output logic [PREG_W-1:0]    wb1_preg,
    output logic [ROB_W-1:0]     wb1_rob,
    output logic [2:0]           wb1_src
);

    localparam int NSRC  = 5;
    localparam int ENT_W = DATA_W + PREG_W + ROB_W;

    // Per-source FIFO storage, entry layout {data, preg, rob}
    logic [ENT_W-1:0] r_mem [NSRC][2];
    logic [NSRC-1:0]  r_wptr;
    logic [NSRC-1:0]  r_rptr;
    logic [1:0]       r_cnt [NSRC];
    logic [2:0]       r_rr;

    logic             w_active;
    logic [NSRC-1:0]  w_hv;
    logic [NSRC-1:0]  w_push;
    logic [NSRC-1:0]  w_pop;
    logic             w_g0_vld;
    logic             w_g1_vld;
    logic [2:0]       w_g0;
    logic [2:0]       w_g1;
    logic [ENT_W-1:0] w_head0;
    logic [ENT_W-1:0] w_head1;

    // Nothing moves in a flush cycle or while reset is held
    assign w_active = rst_n && !flush;

    // Accept side: ready depends only on occupancy and flush, never on valid
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            src_ready[i] = w_active && (r_cnt[i] != 2'd2);
            w_hv[i]      = (r_cnt[i] != 2'd0);
        end
        w_push = src_valid & src_ready;
    end

    // Round-robin scan from r_rr: first occupied head to port 0, next to port 1
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        logic [3:0] sum;
        logic [2:0] idx;
        w_g0_vld = 1'b0;
        w_g1_vld = 1'b0;
        w_g0     = 3'd0;
        w_g1     = 3'd0;
        w_pop    = '0;
        for (int k = 0; k < NSRC; k++) begin
            sum = {1'b0, r_rr} + 4'(k);
            idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
            if (w_active && w_hv[idx]) begin
                if (!w_g0_vld) begin
                    w_g0_vld = 1'b1;
                    w_g0     = idx;
                end else if (!w_g1_vld) begin
                    w_g1_vld = 1'b1;
                    w_g1     = idx;
                end
            end
        end
        if (w_g0_vld) w_pop[w_g0] = 1'b1;
        if (w_g1_vld) w_pop[w_g1] = 1'b1;
    end

    assign w_head0 = r_mem[w_g0][r_rptr[w_g0]];
    assign w_head1 = r_mem[w_g1][r_rptr[w_g1]];

    // Writeback ports: granted head contents, zero when idle
    always_comb begin
        wb0_valid = w_g0_vld;
        wb1_valid = w_g1_vld;
        wb0_src   = w_g0_vld ? w_g0 : 3'd0;
        wb1_src   = w_g1_vld ? w_g1 : 3'd0;
        {wb0_data, wb0_preg, wb0_rob} = w_g0_vld ? w_head0 : '0;
        {wb1_data, wb1_preg, wb1_rob} = w_g1_vld ? w_head1 : '0;
    end

    // FIFO payload write; storage needs no reset since count gates every read
    always_ff @(posedge clk) begin
        // NOTE: the payload array is deliberately not reset; an entry is only
        // ever read while its count says it holds data written by a push.
        for (int i = 0; i < NSRC; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wptr[i]] <= {src_data[i*DATA_W +: DATA_W],
                                        src_preg[i*PREG_W +: PREG_W],
                                        src_rob[i*ROB_W +: ROB_W]};
            end
        end
    end

    // FIFO pointers/counts and round-robin pointer; reset and flush clear all
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n || flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_rr   <= 3'd0;
            for (int i = 0; i < NSRC; i++) r_cnt[i] <= 2'd0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (w_push[i]) r_wptr[i] <= ~r_wptr[i];
                if (w_pop[i])  r_rptr[i] <= ~r_rptr[i];
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + 2'd1;
                    2'b01:   r_cnt[i] <= r_cnt[i] - 2'd1;
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
            if (w_g1_vld) begin
                r_rr <= (w_g1 == 3'd4) ? 3'd0 : w_g1 + 3'd1;
            end else if (w_g0_vld) begin
                r_rr <= (w_g0 == 3'd4) ? 3'd0 : w_g0 + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_exu_wb_arb.sv
// tb_exu_wb_arb: scoreboard bench for exu_wb_arb.
// The driver issues stimulus and pushes every accepted result onto a per-source
// expected queue; the monitor recomputes the round-robin grants from those
// queues, pops the expected heads and compares them with the writeback ports.
module tb_exu_wb_arb;

    localparam int DW = 32;
    localparam int PW = 6;
    localparam int RW = 6;
    localparam int NS = 5;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [PW-1:0] p;
        logic [RW-1:0] r;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [4:0]      src_valid = '0;
    logic [4:0]      src_ready;
    logic [NS*DW-1:0] src_data = '0;
    logic [NS*PW-1:0] src_preg = '0;
    logic [NS*RW-1:0] src_rob = '0;
    logic            wb0_valid, wb1_valid;
    logic [DW-1:0]   wb0_data, wb1_data;
    logic [PW-1:0]   wb0_preg, wb1_preg;
    logic [RW-1:0]   wb0_rob, wb1_rob;
    logic [2:0]      wb0_src, wb1_src;

    ent_t     exp_q [NS][$];
    int       m_rr = 0;
    int       n_checks = 0;
    int       n_pass = 0;
    logic [RW-1:0] rob_ctr = '0;

    always #5 clk = ~clk;

    exu_wb_arb #(.DATA_W(DW), .PREG_W(PW), .ROB_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_data(src_data), .src_preg(src_preg), .src_rob(src_rob),
        .wb0_valid(wb0_valid), .wb0_data(wb0_data), .wb0_preg(wb0_preg),
        .wb0_rob(wb0_rob), .wb0_src(wb0_src),
        .wb1_valid(wb1_valid), .wb1_data(wb1_data), .wb1_preg(wb1_preg),
        .wb1_rob(wb1_rob), .wb1_src(wb1_src)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // One clock of stimulus. Inputs change on the falling edge; ready is
    // compared 1ns later, accepted entries are queued 3ns later (after the
    // monitor has popped this cycle's writebacks).
    task automatic cycle(input logic [4:0] v, input logic fl, input logic rs,
                         input bit fix = 1'b0, input logic [DW-1:0] fd = '0);
        logic [4:0] exp_rdy;
        ent_t e;
        @(negedge clk);
        rst_n = rs;
        flush = fl;
        src_valid = v;
        for (int i = 0; i < NS; i++) begin
            src_data[i*DW +: DW] = $urandom;
            src_preg[i*PW +: PW] = PW'($urandom);
            src_rob[i*RW +: RW]  = rob_ctr;
            rob_ctr = rob_ctr + 1'b1;
        end
        if (fix) begin
            src_data[0 +: DW] = fd;
            src_preg[0 +: PW] = PW'(5);
            src_rob[0 +: RW]  = RW'(3);
        end
        #1;
        for (int i = 0; i < NS; i++)
            exp_rdy[i] = rs && !fl && (exp_q[i].size() < 2);
        check("src_ready", 64'(src_ready), 64'(exp_rdy));
        #2;
        for (int i = 0; i < NS; i++) begin
            if (v[i] && exp_rdy[i]) begin
                e.d = src_data[i*DW +: DW];
                e.p = src_preg[i*PW +: PW];
                e.r = src_rob[i*RW +: RW];
                exp_q[i].push_back(e);
            end
        end
    endtask

    // Monitor: derive grants from queue occupancy and rr, compare, then pop
    initial begin
        int   g0, g1, s;
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (wb1_valid) check("wb1_implies_wb0", 64'(wb0_valid), 64'd1);
            if (!rst_n || flush) begin
                check("wb_valid_idle", 64'({wb0_valid, wb1_valid}), 64'd0);
                check("wb_fields_idle", 64'({wb0_data, wb0_preg, wb0_rob, wb0_src}), 64'd0);
                for (int i = 0; i < NS; i++) exp_q[i].delete();
                m_rr = 0;
            end else begin
                g0 = -1;
                g1 = -1;
                for (int k = 0; k < NS; k++) begin
                    s = (m_rr + k) % NS;
                    if (exp_q[s].size() > 0) begin
                        if (g0 < 0) g0 = s;
                        else if (g1 < 0) g1 = s;
                    end
                end
                check("wb0_valid", 64'(wb0_valid), 64'(g0 >= 0));
                check("wb1_valid", 64'(wb1_valid), 64'(g1 >= 0));
                if (g0 >= 0) begin
                    e = exp_q[g0].pop_front();
                    check("wb0_src", 64'(wb0_src), 64'(g0));
                    check("wb0_payload", 64'({wb0_data, wb0_preg, wb0_rob}), 64'(e));
                end else begin
                    check("wb0_zero", 64'({wb0_data, wb0_preg, wb0_rob, wb0_src}), 64'd0);
                end
                if (g1 >= 0) begin
                    e = exp_q[g1].pop_front();
                    check("wb1_src", 64'(wb1_src), 64'(g1));
                    check("wb1_payload", 64'({wb1_data, wb1_preg, wb1_rob}), 64'(e));
                end else begin
                    check("wb1_zero", 64'({wb1_data, wb1_preg, wb1_rob, wb1_src}), 64'd0);
                end
                if (g1 >= 0)      m_rr = (g1 + 1) % NS;
                else if (g0 >= 0) m_rr = (g0 + 1) % NS;
            end
        end
    end

    // Stimulus sequence
    initial begin
        logic [4:0] v;
        // Reset held: all outputs zero
        repeat (3) cycle(5'b00000, 1'b0, 1'b0);
        // Single push on source 0, then a pair that exercises rr = 1
        cycle(5'b00001, 1'b0, 1'b1, 1'b1, 32'h1234);
        cycle(5'b00000, 1'b0, 1'b1);
        cycle(5'b00011, 1'b0, 1'b1);
        repeat (2) cycle(5'b00000, 1'b0, 1'b1);
        // Burst on all sources then drain: round-robin rotation
        repeat (2) cycle(5'b11111, 1'b0, 1'b1);
        repeat (6) cycle(5'b00000, 1'b0, 1'b1);
        // Saturation: FIFOs fill, ready drops at count 2 with no bypass
        repeat (20) cycle(5'b11111, 1'b0, 1'b1);
        // Flush with pending data and all valids asserted
        cycle(5'b11111, 1'b1, 1'b1);
        repeat (2) cycle(5'b00000, 1'b0, 1'b1);
        // Reset mid-stream with entries buffered
        repeat (2) cycle(5'b10101, 1'b0, 1'b1);
        cycle(5'b00000, 1'b0, 1'b0);
        repeat (3) cycle(5'b00000, 1'b0, 1'b1);
        // Randomized traffic with occasional flush and reset
        for (int c = 0; c < 2000; c++) begin
            v = 5'($urandom);
            if (c % 3 == 0) v = v & 5'($urandom);
            cycle(v, ($urandom_range(63) == 0), !($urandom_range(255) == 0));
        end
        // Drain and confirm every accepted result was written back
        repeat (8) cycle(5'b00000, 1'b0, 1'b1);
        for (int i = 0; i < NS; i++)
            check("drain_empty", 64'(exp_q[i].size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
